// File: rtl/pe_nic_agent_if.sv
// pe_nic_agent_if
// Groups the signals shared by the PE-side NIC agent, the NIC register port
// and the local PE streams.
//   NIC port : addr, d_in, nicEn, nicEnWr (agent drives), d_out (NIC drives)
//   tx stream: tx_data, tx_valid (PE drives), tx_ready (agent drives)
//   rx stream: rx_data, rx_valid (agent drives), rx_ready (PE drives)
// Modports:
//   master - the agent itself
//   slave  - everything around it (NIC + PE, or a bench)
interface pe_nic_agent_if;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicEnWr;

  logic [0:63] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [0:63] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output addr, d_in, nicEn, nicEnWr,
    input  d_out,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  addr, d_in, nicEn, nicEnWr,
    output d_out,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/pe_nic_agent.sv
// pe_nic_agent
// PE-side bus master for one mesh NIC. Polls the NIC input status, drains
// received packets into a single holding register (rx stream), and writes
// locally queued packets (tx stream, FIFO_DEPTH-entry queue) into the NIC
// output buffer whenever the output status reports not-full. Rx and tx
// servicing alternate so neither direction can starve the other.
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous, active-low
//   bus      - pe_nic_agent_if.master (NIC register port + tx/rx streams)
//   tx_count - packets written to the NIC (wraps modulo 2^CNT_W)
//   rx_count - packets read from the NIC  (wraps modulo 2^CNT_W)
module pe_nic_agent #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  pe_nic_agent_if.master    bus,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    POLL_I,
    CHK_I,
    RD_I,
    CAP_I,
    POLL_O,
    CHK_O,
    WR_O
  } state_t;

  state_t state;
  state_t state_next;

  // tx queue storage and bookkeeping
  logic [0:63]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // rx holding register
  logic [0:63] rx_data_q;
  logic        rx_valid_q;

  // combinational bus drive before reset gating
  logic [0:1]  addr_c;
  logic [0:63] d_in_c;
  logic        nic_en_c;
  logic        nic_wr_c;

  assign full  = (occ == DEPTH_CNT);
  assign empty = (occ == '0);
  assign push  = bus.tx_valid && !full;
  // WR_O is only reachable through POLL_O, which requires a non-empty queue
  assign pop   = (state == WR_O);

  assign bus.tx_ready = !full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= POLL_I;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_c     = 2'b00;
    d_in_c     = '0;
    nic_en_c   = 1'b0;
    nic_wr_c   = 1'b0;
    case (state)
      POLL_I: begin
        nic_en_c   = 1'b1;
        addr_c     = 2'b01;
        state_next = CHK_I;
      end
      CHK_I: begin
        // d_out now carries the input status requested in POLL_I; a held
        // rx packet blocks further reads so the mesh backs up naturally
        if (bus.d_out[63] && !rx_valid_q) begin
          state_next = RD_I;
        end else if (!empty) begin
          state_next = POLL_O;
        end else begin
          state_next = POLL_I;
        end
      end
      RD_I: begin
        nic_en_c   = 1'b1;
        addr_c     = 2'b00;
        state_next = CAP_I;
      end
      CAP_I: begin
        state_next = empty ? POLL_I : POLL_O;
      end
      POLL_O: begin
        nic_en_c   = 1'b1;
        addr_c     = 2'b11;
        state_next = CHK_O;
      end
      CHK_O: begin
        state_next = bus.d_out[63] ? POLL_I : WR_O;
      end
      WR_O: begin
        nic_en_c   = 1'b1;
        nic_wr_c   = 1'b1;
        addr_c     = 2'b10;
        d_in_c     = mem[rd_ptr];
        state_next = POLL_I;
      end
      default: begin
        state_next = POLL_I;
      end
    endcase
  end

  // The bus is gated by reset directly so nicEn drops the instant reset is
  // asserted, not at the next clock edge.
  assign bus.nicEn   = nic_en_c & reset;
  assign bus.nicEnWr = nic_wr_c & reset;
  assign bus.addr    = reset ? addr_c : 2'b00;
  assign bus.d_in    = reset ? d_in_c : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_count   <= '0;
    end else begin
      if (state == CAP_I) begin
        // d_out holds the input buffer word requested in RD_I
        rx_data_q  <= bus.d_out;
        rx_valid_q <= 1'b1;
        rx_count   <= rx_count + 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_count <= '0;
    end else if (pop) begin
      tx_count <= tx_count + 1'b1;
    end
  end

endmodule
